oser8_tx_burst_ctrl: RTL
========================

// Module: oser8_tx_burst_ctrl
// PURPOSE
//  pclk-domain front end for LANES OSER8 8:1 serializers (DQ/DQS-style outputs of the DDR PHY).
//  Accepts bursts on a valid/ready stream and frames each one as preamble, data, then postamble.
//  Drives per-lane D0..D7 words and the active-low tristate (TX) bits.
//  Applies a per-lane 0..7-bit slip for write levelling.
// PARAMETERS
//  LANES        1      number of 8-bit serializer lanes
//  PRE_CYCLES   1      pclk cycles of preamble before first data word (0 = none)
//  POST_CYCLES  1      pclk cycles of postamble after last data word (0 = none)
//  IDLE_PAT     8'h00  per-lane word driven while idle (output tristated)
//  PRE_PAT      8'h55  per-lane word driven during preamble and postamble
// PORTS
//  pclk        in   1          slow clock, the only clock
//  rst         in   1          synchronous, active-high reset
//  s_valid     in   1          input word valid
//  s_ready     out  1          block accepts word this cycle
//  s_data      in   LANES*8    lane i = s_data[8i+7:8i]; bit0 is serialized first
//  s_last      in   1          final word of burst
//  slip_amt    in   LANES*3    per-lane bit delay, sampled on IDLE->PRE/DATA
//  ser_d       out  LANES*8    to OSER8 D7..D0 per lane
//  ser_oe_n    out  4          to OSER8 TX3..TX0 (shared by all lanes); 1 = tristate
//  busy        out  1          state != IDLE
//  err_underrun out 1          sticky: s_valid low while in DATA; cleared only by rst
// BEHAVIOUR
//  - Reset values: ser_d = {LANES{IDLE_PAT}}, ser_oe_n = 4'hF, s_ready = 0, busy = 0, err_underrun = 0.
//    State = IDLE; slip registers = 0; prev-word registers = IDLE_PAT.
//  - States and transitions:
//    - IDLE: leave when s_valid=1. Go to PRE, or to DATA if PRE_CYCLES=0. Latch slip_amt on this transition.
//    - PRE: count PRE_CYCLES cycles, then go to DATA.
//    - DATA: on an accepted word with s_last=1, go to POST, or to IDLE if POST_CYCLES=0.
//    - POST: count POST_CYCLES cycles, then go to IDLE.
//  - Handshake:
//    - s_ready = 1 only in DATA; a transfer is s_valid & s_ready.
//    - s_ready is combinational from state only, never from s_valid.
//  - All outputs are registered. An accepted word appears on ser_d the cycle after acceptance.
//    ser_oe_n = 0 for exactly the cycles where PRE/DATA/POST words are driven.
//  - Words driven per state:
//    - PRE/POST drive PRE_PAT on every lane.
//    - IDLE drives IDLE_PAT with ser_oe_n = 4'hF.
//  - Underrun (DATA & !s_valid): the previous data word is driven again and err_underrun is set.
//    State stays DATA.
//  - Slip, per lane, with s = latched slip, cur = new word, prev = last word sent to that lane:
//    - s = 0: out = cur.
//    - s > 0: out = {cur[7-s:0], prev[7:8-s]}, i.e. data is delayed by s UI.
//    - prev updates every cycle with the pre-slip word, so pattern bits carry across state boundaries.
//    - slip_amt changes outside the IDLE exit are ignored.
//  - Counters are sized $clog2(max(PRE_CYCLES,POST_CYCLES)+1) and clear on every state entry.
//  - Back-to-back bursts: when POST ends and s_valid=1, IDLE is held for exactly 1 cycle
//    (oe_n = F) before PRE.
//  - rst mid-burst: next cycle matches the reset values. The word in flight is dropped; no s_ready pulse.
// CONFIGURATION
//  IO_SER8_TRAIN_EN defined:
//  - Adds input train_en (1 bit) and state TRAIN.
//  - IDLE & train_en (priority over s_valid) -> TRAIN. In TRAIN:
//    - every lane drives 8 PRBS7 bits per cycle (x^7+x^6+1, seed 7'h7F at rst, bit0 earliest);
//    - ser_oe_n = 0 and s_ready = 0.
//  - train_en low -> IDLE. The LFSR is held, not reseeded, between TRAIN visits.
//  IO_SER8_TRAIN_EN not defined: no train_en port, no LFSR logic, no TRAIN state.
// TESTING
//  - rst for 2 cycles, then idle 5 cycles
//    -> ser_d=IDLE_PAT, ser_oe_n=F, s_ready=0, busy=0 throughout.
//  - LANES=2, PRE=1, POST=1; burst of 3 words A5C3, 0FF0, 1234 (last), s_valid held high
//    -> outputs: 5555 (oe 0), A5C3, 0FF0, 1234, 5555, then 0000 (oe F).
//  - Same burst with s_valid low for 1 cycle after the 1st word
//    -> A5C3 driven twice, err_underrun=1 and stays 1 until rst.
//  - slip_amt lane0=3 at burst start, PRE_PAT 55, data 8'hFF
//    -> first data word on lane0 = 8'hFA. slip_amt changed to 5 mid-burst has no effect.
//  - rst asserted during DATA of a 4-word burst
//    -> next cycle: reset values on all outputs; a new burst afterwards frames correctly.
//  - IO_SER8_TRAIN_EN: train_en=1 for 3 cycles from IDLE after reset
//    -> 3 words of the PRBS7 sequence from seed 7F with oe_n=0, then IDLE_PAT with oe F.
//       Re-entering TRAIN continues the sequence.

Source files
------------

// File: rtl/oser8_tx_burst_ctrl.sv
// Burst framer for LANES OSER8 8:1 serializers: preamble/data/postamble framing, per-lane bit slip.
// Optional PRBS7 training mode when IO_SER8_TRAIN_EN is defined.
module oser8_tx_burst_ctrl #(
  parameter int         LANES       = 1,
  parameter int         PRE_CYCLES  = 1,
  parameter int         POST_CYCLES = 1,
  parameter logic [7:0] IDLE_PAT    = 8'h00,
  parameter logic [7:0] PRE_PAT     = 8'h55
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [LANES*8-1:0] s_data,
  input  logic               s_last,
  input  logic [LANES*3-1:0] slip_amt,
`ifdef IO_SER8_TRAIN_EN
  input  logic               train_en,
`endif
  output logic [LANES*8-1:0] ser_d,
  output logic [3:0]         ser_oe_n,
  output logic               busy,
  output logic               err_underrun
);

`ifdef IO_SER8_TRAIN_EN
  typedef enum logic [2:0] {IDLE, PRE, DATA, POST, TRAIN} state_e;
`else
  typedef enum logic [1:0] {IDLE, PRE, DATA, POST} state_e;
`endif

  localparam int DW      = LANES * 8;
  localparam int MAX_CYC = (PRE_CYCLES > POST_CYCLES) ? PRE_CYCLES : POST_CYCLES;
  localparam int CW      = (MAX_CYC > 0) ? $clog2(MAX_CYC + 1) : 1;
  localparam logic [CW-1:0] PRE_LAST  = CW'((PRE_CYCLES  > 0) ? PRE_CYCLES  - 1 : 0);
  localparam logic [CW-1:0] POST_LAST = CW'((POST_CYCLES > 0) ? POST_CYCLES - 1 : 0);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [LANES*3-1:0]  slip_q, slip_d;
  logic [DW-1:0]       hold_q, hold_d;
  logic [DW-1:0]       prev_q, prev_d;
  logic [DW-1:0]       ser_d_q, ser_d_d;
  logic [3:0]          oe_q, oe_d;
  logic                err_q, err_d;
  logic [DW-1:0]       cur;
  logic                slip_en;

  // Delay a lane by s UI: low bits come from the tail of the previous word.
  function automatic logic [7:0] slip_word(input logic [7:0] cur_w, input logic [7:0] prev_w,
                                           input logic [2:0] s);
    logic [15:0] pair;
    pair = {cur_w, prev_w} >> (4'd8 - {1'b0, s});
    return pair[7:0];
  endfunction

`ifdef IO_SER8_TRAIN_EN
  logic [6:0] lfsr_q, lfsr_d;
  logic [7:0] prbs_word;
  logic [6:0] lfsr_adv;

  // x^7+x^6+1, eight steps per pclk; bit0 of the word is the earliest bit.
  always_comb begin
    lfsr_adv  = lfsr_q;
    prbs_word = '0;
    for (int k = 0; k < 8; k++) begin
      prbs_word[k] = lfsr_adv[6] ^ lfsr_adv[5];
      lfsr_adv     = {lfsr_adv[5:0], prbs_word[k]};
    end
  end
`endif

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    slip_d  = slip_q;
    hold_d  = hold_q;
    err_d   = err_q;
    oe_d    = 4'hF;
    slip_en = 1'b0;
    cur     = {LANES{IDLE_PAT}};
`ifdef IO_SER8_TRAIN_EN
    lfsr_d  = lfsr_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
`ifdef IO_SER8_TRAIN_EN
        if (train_en) state_d = TRAIN;
        else
`endif
        if (s_valid) begin
          slip_d  = slip_amt;
          state_d = (PRE_CYCLES == 0) ? DATA : PRE;
        end
      end
      PRE: begin
        cur     = {LANES{PRE_PAT}};
        oe_d    = 4'h0;
        slip_en = 1'b1;
        if (cnt_q == PRE_LAST) begin
          cnt_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        oe_d    = 4'h0;
        slip_en = 1'b1;
        if (s_valid) begin
          cur    = s_data;
          hold_d = s_data;
          if (s_last) begin
            cnt_d   = '0;
            state_d = (POST_CYCLES == 0) ? IDLE : POST;
          end
        end else begin
          // Underrun: repeat the last accepted word and flag it until reset.
          cur   = hold_q;
          err_d = 1'b1;
        end
      end
      POST: begin
        cur     = {LANES{PRE_PAT}};
        oe_d    = 4'h0;
        slip_en = 1'b1;
        if (cnt_q == POST_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef IO_SER8_TRAIN_EN
      TRAIN: begin
        cur    = {LANES{prbs_word}};
        oe_d   = 4'h0;
        lfsr_d = lfsr_adv;
        if (!train_en) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase

    prev_d = cur;
    for (int i = 0; i < LANES; i++) begin
      ser_d_d[8*i +: 8] = slip_en ? slip_word(cur[8*i +: 8], prev_q[8*i +: 8], slip_q[3*i +: 3])
                                  : cur[8*i +: 8];
    end
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      slip_q  <= '0;
      hold_q  <= {LANES{IDLE_PAT}};
      prev_q  <= {LANES{IDLE_PAT}};
      ser_d_q <= {LANES{IDLE_PAT}};
      oe_q    <= 4'hF;
      err_q   <= 1'b0;
`ifdef IO_SER8_TRAIN_EN
      lfsr_q  <= 7'h7F;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slip_q  <= slip_d;
      hold_q  <= hold_d;
      prev_q  <= prev_d;
      ser_d_q <= ser_d_d;
      oe_q    <= oe_d;
      err_q   <= err_d;
`ifdef IO_SER8_TRAIN_EN
      lfsr_q  <= lfsr_d;
`endif
    end
  end

  // Gated by rst so a reset cycle never looks like an accepted transfer.
  assign s_ready      = (state_q == DATA) && !rst;
  assign busy         = (state_q != IDLE);
  assign ser_d        = ser_d_q;
  assign ser_oe_n     = oe_q;
  assign err_underrun = err_q;

endmodule
